fb_port_arbiter: RTL

FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

---
 rtl/fb_port_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one single-port frame-buffer RAM between a raster
// writer and a display scan-out reader, with frame-swap control.
//
// Build option: define FB_DOUBLE_BUF_EN to enable double buffering (buffer
// select in mem_addr[19], front_sel toggling, and raster writes held off
// while a swap is pending). Without it, there is one buffer: swap_done still
// pulses, but front_sel and mem_addr[19] stay 0.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   wr_req/x/y/color    raster pixel write; wr_ready = combinational grant
//   rd_req/x/y          display read; rd_ready = combinational grant
//   rd_valid, rd_data   read return, 2 cycles after the read grant
//   swap_req, vsync     frame-complete level; vertical-blank pulse
//   swap_done,front_sel swap pulse; current display buffer
//   mem_*               registered RAM port (1-cycle read latency)
module fb_port_arbiter #(
  parameter int STARVE_MAX = 7,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [9:0]  wr_x,
  input  logic [9:0]  wr_y,
  input  logic [2:0]  wr_color,
  output logic        wr_ready,
  input  logic        rd_req,
  input  logic [9:0]  rd_x,
  input  logic [9:0]  rd_y,
  output logic        rd_ready,
  output logic        rd_valid,
  output logic [2:0]  rd_data,
  input  logic        swap_req,
  input  logic        vsync,
  output logic        swap_done,
  output logic        front_sel,
  output logic        mem_en,
  output logic        mem_we,
  output logic [19:0] mem_addr,
  output logic [2:0]  mem_wdata,
  input  logic [2:0]  mem_rdata
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WAIT_CLR} swap_state_t;

  swap_state_t   state_q, state_d;
  logic          swap_req_q;
  logic          swap_pulse;
  logic          swap_done_q;
  logic [CW-1:0] starve_q, starve_d;
  logic          mem_en_q, mem_we_q;
  logic [19:0]   mem_addr_q;
  logic [2:0]    mem_wdata_q;
  logic          rd_p1_q, rd_p1_oob_q;
  logic          rd_valid_q, rd_oob_q;

  logic          wr_allow, wr_win, raster_pri;
  logic          wr_in_range, rd_in_range;
  logic [18:0]   wr_lin, rd_lin;
  logic          wr_bank, rd_bank;

`ifdef FB_DOUBLE_BUF_EN
  logic          front_sel_q;
  assign front_sel = front_sel_q;
  assign wr_bank   = ~front_sel_q;
  assign rd_bank   = front_sel_q;
  // Raster is held off from ARMED until swap_req drops, so it never draws
  // into a buffer that is about to become, or has just become, front.
  assign wr_allow  = (state_q == S_IDLE);
`else
  assign front_sel = 1'b0;
  assign wr_bank   = 1'b0;
  assign rd_bank   = 1'b0;
  assign wr_allow  = 1'b1;
`endif

  assign wr_in_range = ({1'b0, wr_x} < 11'(H_RES)) && ({1'b0, wr_y} < 11'(V_RES));
  assign rd_in_range = ({1'b0, rd_x} < 11'(H_RES)) && ({1'b0, rd_y} < 11'(V_RES));
  assign wr_lin      = 19'(wr_y) * 19'(H_RES) + 19'(wr_x);
  assign rd_lin      = 19'(rd_y) * 19'(H_RES) + 19'(rd_x);

  // Display has priority; raster wins when starved, or when display is idle.
  assign raster_pri = (starve_q == CW'(STARVE_MAX));
  assign wr_win     = wr_req & wr_allow & (raster_pri | ~rd_req);
  assign wr_ready   = rst & wr_win;
  assign rd_ready   = rst & rd_req & ~wr_win;

  always_comb begin
    starve_d = '0;
    if (wr_req && !wr_ready)
      starve_d = raster_pri ? starve_q : starve_q + 1'b1;
  end

  // Swap FSM: a swap_req rise only arms; vsync in the arming cycle is ignored.
  always_comb begin
    state_d    = state_q;
    swap_pulse = 1'b0;
    case (state_q)
      S_IDLE:     if (swap_req && !swap_req_q) state_d = S_ARMED;
      S_ARMED:    if (vsync) begin
                    state_d    = S_WAIT_CLR;
                    swap_pulse = 1'b1;
                  end
      S_WAIT_CLR: if (!swap_req) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      swap_req_q  <= 1'b0;
      swap_done_q <= 1'b0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_p1_q     <= 1'b0;
      rd_p1_oob_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_oob_q    <= 1'b0;
`ifdef FB_DOUBLE_BUF_EN
      front_sel_q <= 1'b0;
`endif
    end else begin
      swap_req_q  <= swap_req;
      swap_done_q <= swap_pulse;
      starve_q    <= starve_d;
`ifdef FB_DOUBLE_BUF_EN
      front_sel_q <= front_sel_q ^ swap_pulse;
`endif
      // Buffer bit is taken at grant time, so a same-edge toggle does not
      // affect the access being registered here.
      if (wr_ready) begin
        mem_en_q    <= wr_in_range;
        mem_we_q    <= wr_in_range;
        mem_addr_q  <= {wr_bank, wr_lin};
        mem_wdata_q <= wr_color;
      end else if (rd_ready) begin
        mem_en_q    <= rd_in_range;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= {rd_bank, rd_lin};
        mem_wdata_q <= '0;
      end else begin
        mem_en_q    <= 1'b0;
        mem_we_q    <= 1'b0;
      end
      rd_p1_q     <= rd_ready;
      rd_p1_oob_q <= ~rd_in_range;
      rd_valid_q  <= rd_p1_q;
      rd_oob_q    <= rd_p1_oob_q;
    end
  end

  assign swap_done = swap_done_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = (rd_valid_q && !rd_oob_q) ? mem_rdata : '0;

endmodule
